// File: rtl/wall_clock_pkg.sv
// Shared defaults and types for the wall-clock timestamp block.
package wall_clock_pkg;

    localparam int DEF_TS_WIDTH       = 32;
    localparam int DEF_PRESCALE_WIDTH = 8;
    localparam int DEF_EPOCH_WIDTH    = 16;
    localparam int DEF_NUM_CH         = 4;

    typedef logic [DEF_TS_WIDTH-1:0]    timestamp_t;
    typedef logic [DEF_EPOCH_WIDTH-1:0] epoch_t;

endpackage

// File: rtl/wall_clock_capture_slot.sv
// One capture channel: one-deep timestamp slot drained by valid/ready,
// with a sticky overrun flag for events dropped while the slot is blocked.
module ts_capture_slot #(
    parameter int TS_WIDTH = 32
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic [TS_WIDTH-1:0] ts_i,
    input  logic                event_i,
    input  logic                ready_i,
    input  logic                overrun_clr_i,
    output logic [TS_WIDTH-1:0] cap_ts_o,
    output logic                cap_valid_o,
    output logic                overrun_o
);

    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic                valid_q, valid_d;
    logic                ovr_q, ovr_d;
    logic                fire;
    logic                accept;
    logic                drop;

    // Valid/ready: a transfer occurs in any cycle where valid and ready are both
    // high; the slot refills in that same cycle if an event is present.
    assign fire   = valid_q & ready_i;
    assign accept = event_i & (~valid_q | ready_i);
    assign drop   = event_i & valid_q & ~ready_i;

    always_comb begin
        ts_d    = ts_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (accept) begin
            ts_d    = ts_i;
            valid_d = 1'b1;
        end else if (fire) begin
            valid_d = 1'b0;
        end
        if (drop) begin
            ovr_d = 1'b1;
        end else if (overrun_clr_i) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ts_q    <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ts_q    <= ts_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign cap_ts_o    = ts_q;
    assign cap_valid_o = valid_q;
    assign overrun_o   = ovr_q;

endmodule

// File: rtl/wall_clock_capture.sv
// Free-running prescaled timestamp with load, wrap pulse and epoch counter,
// plus NUM_CH independent event-capture slots.
module wall_clock_capture
    import wall_clock_pkg::*;
#(
    parameter int TS_WIDTH       = DEF_TS_WIDTH,
    parameter int PRESCALE_WIDTH = DEF_PRESCALE_WIDTH,
    parameter int EPOCH_WIDTH    = DEF_EPOCH_WIDTH,
    parameter int NUM_CH         = DEF_NUM_CH
) (
    input  logic                              clk_i,
    input  logic                              reset_ni,
    input  logic                              enable_i,
    input  logic [PRESCALE_WIDTH-1:0]         prescale_i,
    input  logic                              load_i,
    input  logic [TS_WIDTH-1:0]               load_val_i,
    output logic [TS_WIDTH-1:0]               timestamp_o,
    output logic                              wrap_o,
    output logic [EPOCH_WIDTH-1:0]            epoch_o,
    input  logic [NUM_CH-1:0]                 event_i,
    output logic [NUM_CH-1:0][TS_WIDTH-1:0]   cap_ts_o,
    output logic [NUM_CH-1:0]                 cap_valid_o,
    input  logic [NUM_CH-1:0]                 cap_ready_i,
    output logic [NUM_CH-1:0]                 overrun_o,
    input  logic [NUM_CH-1:0]                 overrun_clr_i
);

    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
    logic [TS_WIDTH-1:0]       ts_q, ts_d;
    logic                      wrap_q, wrap_d;
    logic [EPOCH_WIDTH-1:0]    epoch_q, epoch_d;
    logic                      tick;

    // >= rather than == so lowering prescale_i below the running count ticks at once.
    assign tick = enable_i & (presc_q >= prescale_i);

    always_comb begin
        presc_d = presc_q;
        ts_d    = ts_q;
        wrap_d  = 1'b0;
        epoch_d = epoch_q;
        if (load_i) begin
            ts_d    = load_val_i;
            presc_d = '0;
        end else if (tick) begin
            presc_d = '0;
            ts_d    = ts_q + TS_WIDTH'(1);
            if (&ts_q) begin
                wrap_d  = 1'b1;
                epoch_d = epoch_q + EPOCH_WIDTH'(1);
            end
        end else if (enable_i) begin
            presc_d = presc_q + PRESCALE_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            presc_q <= '0;
            ts_q    <= '0;
            wrap_q  <= 1'b0;
            epoch_q <= '0;
        end else begin
            presc_q <= presc_d;
            ts_q    <= ts_d;
            wrap_q  <= wrap_d;
            epoch_q <= epoch_d;
        end
    end

    assign timestamp_o = ts_q;
    assign wrap_o      = wrap_q;
    assign epoch_o     = epoch_q;

    // Every slot samples the same pre-update timestamp.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ts_capture_slot #(
            .TS_WIDTH(TS_WIDTH)
        ) u_slot (
            .clk_i         (clk_i),
            .reset_ni      (reset_ni),
            .ts_i          (ts_q),
            .event_i       (event_i[c]),
            .ready_i       (cap_ready_i[c]),
            .overrun_clr_i (overrun_clr_i[c]),
            .cap_ts_o      (cap_ts_o[c]),
            .cap_valid_o   (cap_valid_o[c]),
            .overrun_o     (overrun_o[c])
        );
    end

endmodule

// File: tb/tb_wall_clock_capture.sv
// Randomized and directed checking of wall_clock_capture against a cycle-level reference model.
module tb_wall_clock_capture;
    import wall_clock_pkg::*;

    localparam int TW = 32;
    localparam int PW = 8;
    localparam int EW = 16;
    localparam int NC = 4;

    logic                    clk = 1'b0;
    logic                    reset_ni = 1'b0;
    logic                    enable_i = 1'b0;
    logic [PW-1:0]           prescale_i = '0;
    logic                    load_i = 1'b0;
    logic [TW-1:0]           load_val_i = '0;
    logic [TW-1:0]           timestamp_o;
    logic                    wrap_o;
    logic [EW-1:0]           epoch_o;
    logic [NC-1:0]           event_i = '0;
    logic [NC-1:0][TW-1:0]   cap_ts_o;
    logic [NC-1:0]           cap_valid_o;
    logic [NC-1:0]           cap_ready_i = '0;
    logic [NC-1:0]           overrun_o;
    logic [NC-1:0]           overrun_clr_i = '0;

    int total = 0;
    int bad   = 0;

    // Reference state
    longint unsigned m_ts;
    int unsigned     m_cnt;
    logic            m_wrap;
    int unsigned     m_epoch;
    logic            m_full[NC];
    longint unsigned m_cap[NC];
    logic            m_ovr[NC];

    wall_clock_capture #(
        .TS_WIDTH(TW), .PRESCALE_WIDTH(PW), .EPOCH_WIDTH(EW), .NUM_CH(NC)
    ) dut (
        .clk_i(clk), .reset_ni(reset_ni), .enable_i(enable_i), .prescale_i(prescale_i),
        .load_i(load_i), .load_val_i(load_val_i), .timestamp_o(timestamp_o),
        .wrap_o(wrap_o), .epoch_o(epoch_o), .event_i(event_i), .cap_ts_o(cap_ts_o),
        .cap_valid_o(cap_valid_o), .cap_ready_i(cap_ready_i), .overrun_o(overrun_o),
        .overrun_clr_i(overrun_clr_i)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ts = 0; m_cnt = 0; m_wrap = 1'b0; m_epoch = 0;
        for (int c = 0; c < NC; c++) begin
            m_full[c] = 1'b0; m_cap[c] = 0; m_ovr[c] = 1'b0;
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        logic lost;
        for (int c = 0; c < NC; c++) begin
            lost = event_i[c] && m_full[c] && !cap_ready_i[c];
            if (event_i[c] && !lost) begin
                m_full[c] = 1'b1;
                m_cap[c]  = m_ts;
            end else if (m_full[c] && cap_ready_i[c]) begin
                m_full[c] = 1'b0;
            end
            if (lost) m_ovr[c] = 1'b1;
            else if (overrun_clr_i[c]) m_ovr[c] = 1'b0;
        end
        m_wrap = 1'b0;
        if (load_i) begin
            m_ts  = load_val_i;
            m_cnt = 0;
        end else if (enable_i) begin
            if (m_cnt >= prescale_i) begin
                m_cnt = 0;
                m_ts  = m_ts + 1;
                if (m_ts == (64'd1 << TW)) begin
                    m_ts    = 0;
                    m_wrap  = 1'b1;
                    m_epoch = (m_epoch + 1) % (1 << EW);
                end
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    task automatic check_all();
        check_eq("timestamp", timestamp_o, m_ts);
        check_eq("wrap", wrap_o, m_wrap);
        check_eq("epoch", epoch_o, m_epoch);
        for (int c = 0; c < NC; c++) begin
            check_eq($sformatf("valid%0d", c), cap_valid_o[c], m_full[c]);
            check_eq($sformatf("ovr%0d", c), overrun_o[c], m_ovr[c]);
            if (m_full[c]) check_eq($sformatf("capts%0d", c), cap_ts_o[c], m_cap[c]);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        load_i = 1'b0; event_i = '0; cap_ready_i = '0; overrun_clr_i = '0;
    endtask

    task automatic do_reset();
        reset_ni = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge clk);
        #1;
        reset_ni = 1'b1;
    endtask

    initial begin
        idle_inputs();
        #2;
        do_reset();

        // Count with no prescale, then reset mid-count.
        enable_i = 1'b1; prescale_i = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check_eq("count_p0", timestamp_o, i + 1);
        end
        #3;
        do_reset();

        // Prescale 3: one step per 4 cycles, then freeze.
        prescale_i = 3;
        repeat (12) cycle();
        check_eq("presc3_ts", timestamp_o, 3);
        repeat (2) cycle();
        enable_i = 1'b0;
        repeat (5) cycle();
        check_eq("frozen_ts", timestamp_o, 3);
        enable_i = 1'b1;
        repeat (3) cycle();
        check_eq("phase_kept", timestamp_o, 4);

        // Load near all-ones and wrap.
        prescale_i = 0;
        load_i = 1'b1; load_val_i = 32'hFFFF_FFFE;
        cycle();
        load_i = 1'b0;
        check_eq("load_ts", timestamp_o, 32'hFFFF_FFFE);
        cycle();
        check_eq("ts_ones", timestamp_o, 32'hFFFF_FFFF);
        cycle();
        check_eq("wrap_ts", timestamp_o, 0);
        check_eq("wrap_pulse", wrap_o, 1);
        check_eq("epoch1", epoch_o, 1);
        cycle();
        check_eq("wrap_clear", wrap_o, 0);
        load_i = 1'b1; load_val_i = 32'h10;
        cycle();
        check_eq("load_beats_tick", timestamp_o, 32'h10);

        // Capture, overrun and clear on channel 2.
        enable_i = 1'b0; load_i = 1'b0;
        event_i = 4'b0100;
        cycle();
        check_eq("cap2_ts", cap_ts_o[2], 32'h10);
        check_eq("cap2_valid", cap_valid_o[2], 1);
        load_i = 1'b1; load_val_i = 32'h18;
        cycle();
        load_i = 1'b0; event_i = '0;
        check_eq("cap2_hold", cap_ts_o[2], 32'h10);
        check_eq("ovr2_set", overrun_o[2], 1);
        overrun_clr_i = 4'b0100;
        cycle();
        overrun_clr_i = '0;
        check_eq("ovr2_clr", overrun_o[2], 0);

        // Refill during the handshake.
        load_i = 1'b1; load_val_i = 32'h20;
        cycle();
        load_i = 1'b0;
        event_i = 4'b0100; cap_ready_i = 4'b0100;
        cycle();
        idle_inputs();
        check_eq("refill_ts", cap_ts_o[2], 32'h20);
        check_eq("refill_valid", cap_valid_o[2], 1);
        check_eq("refill_ovr", overrun_o[2], 0);
        cap_ready_i = 4'b0100;
        cycle();
        cap_ready_i = '0;

        // All channels at once, drained 3,1,0,2.
        load_i = 1'b1; load_val_i = 32'h55;
        cycle();
        load_i = 1'b0; event_i = 4'b1111;
        cycle();
        event_i = '0;
        for (int c = 0; c < NC; c++) check_eq("all_ts", cap_ts_o[c], 32'h55);
        cap_ready_i = 4'b1000; cycle();
        check_eq("drain3", cap_valid_o, 4'b0111);
        cap_ready_i = 4'b0010; cycle();
        check_eq("drain1", cap_valid_o, 4'b0101);
        cap_ready_i = 4'b0001; cycle();
        check_eq("drain0", cap_valid_o, 4'b0100);
        cap_ready_i = 4'b0100; cycle();
        check_eq("drain2", cap_valid_o, 4'b0000);
        idle_inputs();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            enable_i = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 19) == 0) prescale_i = PW'($urandom_range(0, 4));
            load_i = ($urandom_range(0, 49) == 0);
            load_val_i = ($urandom_range(0, 1) == 1) ? (32'hFFFF_FFF8 + 32'($urandom_range(0, 7)))
                                                      : 32'($urandom);
            event_i       = NC'($urandom);
            cap_ready_i   = NC'($urandom);
            overrun_clr_i = ($urandom_range(0, 3) == 0) ? NC'($urandom) : '0;
            cycle();
            if (i == 1500) begin
                #2;
                do_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
